ser2par_gearbox: RTL and testbench
==================================

SER2PAR_GEARBOX -- requirements
Module: ser2par_gearbox

Interface
REQ-001 SHALL have parameter IN_W, default 1, bits per input beat (1..16).
REQ-002 SHALL have parameter BEATS, default 8, input beats per output word (2..64); OUT_W = IN_W*BEATS is derived, not overridable.
REQ-003 SHALL have parameter LSB_FIRST, default 1: first beat lands in slice 0 (bits IN_W-1:0); when 0, first beat lands in slice BEATS-1.
REQ-004 SHALL have ports, with reset rst_n (asynchronous, active-low) and clock clk:
  clk  in  1  clock
  rst_n  in  1  asynchronous active-low reset
  s_data  in  IN_W  input beat
  s_valid  in  1  input beat valid
  s_last  in  1  beat ends frame; flush partial word
  s_ready  out  1  block accepts beat
  m_data  out  OUT_W  assembled word
  m_keep  out  BEATS  per-slice valid mask
  m_last  out  1  word carries frame end
  m_valid  out  1  output word valid
  m_ready  in  1  downstream accepts word

Function
REQ-005 SHALL accept a beat on any rising clk edge with s_valid=1 and s_ready=1, and SHALL ignore s_data/s_last otherwise.
REQ-006 SHALL write each accepted beat into the assembly buffer at slice index cnt (LSB_FIRST=1) or BEATS-1-cnt (LSB_FIRST=0); cnt is the beat counter, range 0..BEATS-1.
REQ-007 SHALL complete a word on an accepted beat with cnt==BEATS-1 or s_last=1; cnt returns to 0 on completion, otherwise increments by 1.
REQ-008 SHALL zero-fill unwritten slices of a partial word; m_keep bit i is 1 exactly for written slices; m_last equals s_last of the completing beat.
REQ-009 SHALL hold a two-stage buffer: assembly buffer plus output register (m_data/m_keep/m_last/m_valid).
REQ-010 SHALL, on completion with the output register free (m_valid=0, or m_valid=1 and m_ready=1 in the same cycle), load the output register at that edge; m_valid=1 the next cycle (latency 1 cycle from completing beat).
REQ-011 SHALL, on completion with the output register occupied and m_ready=0, set flag asm_full; s_ready SHALL equal !asm_full (registered, no combinational path from m_ready).
REQ-012 SHALL, while asm_full=1, move the held word into the output register on the edge where m_valid=1 and m_ready=1, and clear asm_full on that edge.
REQ-013 SHALL clear m_valid on an edge with m_valid=1, m_ready=1 and no word to load.
REQ-014 SHALL hold m_data, m_keep and m_last stable while m_valid=1 and m_ready=0.
REQ-015 SHALL sustain one beat per cycle indefinitely when m_ready is held 1.
REQ-016 SHALL treat s_last on the first beat of a word as a one-slice word.

Reset
REQ-017 SHALL, on rst_n=0 at any time including mid-word, asynchronously clear cnt, asm_full, the assembly buffer, m_data, m_keep, m_last and m_valid to 0, discarding any partial word.
REQ-018 SHALL drive s_ready=1 from the first cycle after rst_n deasserts.

Structure
REQ-019 SHALL place the default IN_W/BEATS/LSB_FIRST constants and the slice-index helper function in shared package ofdm_s2p_pkg.
REQ-020 SHALL instantiate one sub-module, beat_counter (BEATS-modulo counter with enable, synchronous clear and last flag).

Verification
REQ-021 IN_W=1, BEATS=8, LSB_FIRST=1, beats 1,0,1,1,0,0,1,0, m_ready=1 -> m_data=0x4D, m_keep=0xFF, m_valid high 1 cycle after 8th beat.
REQ-022 Same config, LSB_FIRST=0, same beats -> m_data=0xB2.
REQ-023 IN_W=4, BEATS=4, beats 0xA,0xB with s_last on 2nd -> m_data=0x00BA, m_keep=0x3, m_last=1.
REQ-024 m_ready=0, 16 one-bit beats streamed -> first word held, s_ready=0 after 16th beat; raise m_ready -> both words delivered in order, no loss or duplication.
REQ-025 rst_n pulsed after 5 beats -> m_valid=0, s_ready=1; next 8 beats form a clean word with m_keep=0xFF.
REQ-026 Random s_valid/m_ready, 10k beats -> scoreboard matches reference packing; full throughput while m_ready=1.

Source files
------------

// File: rtl/ofdm_s2p_pkg.sv
// Shared defaults and slice-placement helper for the serial-to-parallel gearbox.
`timescale 1ns/1ps
package ofdm_s2p_pkg;

  localparam int DEF_IN_W      = 1;
  localparam int DEF_BEATS     = 8;
  localparam bit DEF_LSB_FIRST = 1'b1;

  // Slice that beat number cnt of a word occupies in the assembled word.
  function automatic int slice_idx(input int cnt, input int beats, input bit lsb_first);
    return lsb_first ? cnt : (beats - 1 - cnt);
  endfunction

endpackage

// File: rtl/beat_counter.sv
// Modulo-BEATS beat counter with enable, synchronous clear and a last-beat flag.
`timescale 1ns/1ps
module beat_counter #(
  parameter int BEATS = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     en,
  input  logic                     clr,
  output logic [$clog2(BEATS)-1:0] cnt,
  output logic                     last
);

  localparam int CW = $clog2(BEATS);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  assign last = (cnt_q == CW'(BEATS - 1));
  assign cnt  = cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = last ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/ser2par_gearbox.sv
// Packs IN_W-bit beats into IN_W*BEATS-bit words; an assembly buffer plus an
// output register give one word of slack so s_ready never depends on m_ready.
`timescale 1ns/1ps
module ser2par_gearbox
  import ofdm_s2p_pkg::*;
#(
  parameter int IN_W      = DEF_IN_W,
  parameter int BEATS     = DEF_BEATS,
  parameter bit LSB_FIRST = DEF_LSB_FIRST
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [IN_W-1:0]       s_data,
  input  logic                  s_valid,
  input  logic                  s_last,
  output logic                  s_ready,
  output logic [IN_W*BEATS-1:0] m_data,
  output logic [BEATS-1:0]      m_keep,
  output logic                  m_last,
  output logic                  m_valid,
  input  logic                  m_ready
);

  localparam int OUT_W = IN_W * BEATS;
  localparam int CW    = $clog2(BEATS);

  logic [OUT_W-1:0] asm_data_q, asm_data_d;
  logic [BEATS-1:0] asm_keep_q, asm_keep_d;
  logic             asm_last_q, asm_last_d;
  logic             asm_full_q, asm_full_d;
  logic [OUT_W-1:0] m_data_q, m_data_d;
  logic [BEATS-1:0] m_keep_q, m_keep_d;
  logic             m_last_q, m_last_d;
  logic             m_valid_q, m_valid_d;

  logic [CW-1:0]    cnt;
  logic             cnt_last;
  logic             accept;
  logic             complete;
  logic             out_free;
  logic [BEATS-1:0] wr_sel;
  logic [OUT_W-1:0] merged_data;
  logic [BEATS-1:0] merged_keep;

  assign s_ready  = !asm_full_q;
  assign accept   = s_valid && !asm_full_q;
  assign complete = accept && (cnt_last || s_last);
  assign out_free = !m_valid_q || m_ready;

  beat_counter #(
    .BEATS (BEATS)
  ) u_beat_counter (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (accept),
    .clr   (accept && s_last),
    .cnt   (cnt),
    .last  (cnt_last)
  );

  // Word as it stands once the incoming beat is written into its slice.
  for (genvar gi = 0; gi < BEATS; gi++) begin : g_slice
    assign wr_sel[gi] = accept && (slice_idx(int'(cnt), BEATS, LSB_FIRST) == gi);
    assign merged_data[gi*IN_W +: IN_W] = wr_sel[gi] ? s_data : asm_data_q[gi*IN_W +: IN_W];
  end
  assign merged_keep = asm_keep_q | wr_sel;

  always_comb begin
    asm_data_d = asm_data_q;
    asm_keep_d = asm_keep_q;
    asm_last_d = asm_last_q;
    asm_full_d = asm_full_q;
    m_data_d   = m_data_q;
    m_keep_d   = m_keep_q;
    m_last_d   = m_last_q;
    m_valid_d  = m_valid_q;

    if (m_valid_q && m_ready) begin
      m_valid_d = 1'b0;
    end

    if (asm_full_q) begin
      // A held word only exists while the output register is occupied.
      if (m_valid_q && m_ready) begin
        m_data_d   = asm_data_q;
        m_keep_d   = asm_keep_q;
        m_last_d   = asm_last_q;
        m_valid_d  = 1'b1;
        asm_data_d = '0;
        asm_keep_d = '0;
        asm_last_d = 1'b0;
        asm_full_d = 1'b0;
      end
    end else if (accept) begin
      if (!complete) begin
        asm_data_d = merged_data;
        asm_keep_d = merged_keep;
      end else if (out_free) begin
        m_data_d   = merged_data;
        m_keep_d   = merged_keep;
        m_last_d   = s_last;
        m_valid_d  = 1'b1;
        asm_data_d = '0;
        asm_keep_d = '0;
        asm_last_d = 1'b0;
      end else begin
        asm_data_d = merged_data;
        asm_keep_d = merged_keep;
        asm_last_d = s_last;
        asm_full_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      asm_data_q <= '0;
      asm_keep_q <= '0;
      asm_last_q <= 1'b0;
      asm_full_q <= 1'b0;
      m_data_q   <= '0;
      m_keep_q   <= '0;
      m_last_q   <= 1'b0;
      m_valid_q  <= 1'b0;
    end else begin
      asm_data_q <= asm_data_d;
      asm_keep_q <= asm_keep_d;
      asm_last_q <= asm_last_d;
      asm_full_q <= asm_full_d;
      m_data_q   <= m_data_d;
      m_keep_q   <= m_keep_d;
      m_last_q   <= m_last_d;
      m_valid_q  <= m_valid_d;
    end
  end

  assign m_data  = m_data_q;
  assign m_keep  = m_keep_q;
  assign m_last  = m_last_q;
  assign m_valid = m_valid_q;

endmodule

// File: tb/tb_ser2par_gearbox.sv
// Three gearbox configurations driven side by side and compared each cycle
// against a word-level packing model with an ordered queue of pending words.
`timescale 1ns/1ps
module tb_ser2par_gearbox;

  typedef struct packed {
    logic [15:0] data;
    logic [7:0]  keep;
    logic        last;
  } word_t;

  logic       clk;
  logic       rst_n;
  logic [2:0] sv, sl, mr;
  logic [3:0] sd [3];

  logic [7:0]  md0, md1, mk0, mk1;
  logic [15:0] md2;
  logic [3:0]  mk2;
  logic [2:0]  ml, mv, srdy;

  int checks   = 0;
  int failures = 0;
  int acc0     = 0;

  word_t       exp_q [3][2];
  int          n     [3];
  logic [15:0] pdata [3];
  logic [7:0]  pkeep [3];
  int          pc    [3];
  logic [2:0]  mr_prev;

  ser2par_gearbox #(.IN_W(1), .BEATS(8), .LSB_FIRST(1'b1)) dut0 (
    .clk(clk), .rst_n(rst_n), .s_data(sd[0][0:0]), .s_valid(sv[0]), .s_last(sl[0]),
    .s_ready(srdy[0]), .m_data(md0), .m_keep(mk0), .m_last(ml[0]), .m_valid(mv[0]),
    .m_ready(mr[0]));

  ser2par_gearbox #(.IN_W(1), .BEATS(8), .LSB_FIRST(1'b0)) dut1 (
    .clk(clk), .rst_n(rst_n), .s_data(sd[1][0:0]), .s_valid(sv[1]), .s_last(sl[1]),
    .s_ready(srdy[1]), .m_data(md1), .m_keep(mk1), .m_last(ml[1]), .m_valid(mv[1]),
    .m_ready(mr[1]));

  ser2par_gearbox #(.IN_W(4), .BEATS(4), .LSB_FIRST(1'b1)) dut2 (
    .clk(clk), .rst_n(rst_n), .s_data(sd[2]), .s_valid(sv[2]), .s_last(sl[2]),
    .s_ready(srdy[2]), .m_data(md2), .m_keep(mk2), .m_last(ml[2]), .m_valid(mv[2]),
    .m_ready(mr[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int w_of(input int i);
    return (i == 2) ? 4 : 1;
  endfunction
  function automatic int b_of(input int i);
    return (i == 2) ? 4 : 8;
  endfunction
  function automatic bit l_of(input int i);
    return (i != 1);
  endfunction

  function automatic logic [15:0] act_data(input int i);
    case (i)
      0:       return {8'h00, md0};
      1:       return {8'h00, md1};
      default: return md2;
    endcase
  endfunction
  function automatic logic [7:0] act_keep(input int i);
    case (i)
      0:       return mk0;
      1:       return mk1;
      default: return {4'h0, mk2};
    endcase
  endfunction

  task automatic cmp(input string nm, input int i, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s inst%0d actual=0x%0h required=0x%0h t=%0t", nm, i, act, req, $time);
    end
  endtask

  function automatic void model_reset();
    for (int i = 0; i < 3; i++) begin
      n[i] = 0; pdata[i] = '0; pkeep[i] = '0; pc[i] = 0;
    end
    mr_prev = 3'b000;
  endfunction

  // Advance the model across the coming rising edge using the inputs now driven.
  function automatic void model_step(input int i);
    bit          pop, acc;
    int          pos;
    logic [15:0] beat;
    pop = (n[i] > 0) && mr[i];
    acc = sv[i] && (n[i] < 2);
    if (pop) begin
      $display("word inst%0d data=0x%0h keep=0x%0h last=%0b",
               i, exp_q[i][0].data, exp_q[i][0].keep, exp_q[i][0].last);
      exp_q[i][0] = exp_q[i][1];
      n[i]--;
    end
    if (acc) begin
      pos  = l_of(i) ? pc[i] : (b_of(i) - 1 - pc[i]);
      beat = 16'(sd[i]) & 16'((1 << w_of(i)) - 1);
      pdata[i] = pdata[i] | (beat << (pos * w_of(i)));
      pkeep[i][pos] = 1'b1;
      pc[i]++;
      if (sl[i] || pc[i] == b_of(i)) begin
        exp_q[i][n[i]] = '{data: pdata[i], keep: pkeep[i], last: sl[i]};
        n[i]++;
        pdata[i] = '0; pkeep[i] = '0; pc[i] = 0;
      end
      if (i == 0) acc0++;
    end
  endfunction

  task automatic check_all();
    for (int i = 0; i < 3; i++) begin
      cmp("m_valid", i, 32'(mv[i]), 32'(n[i] > 0));
      cmp("s_ready", i, 32'(srdy[i]), 32'(n[i] < 2));
      if (mr_prev[i]) cmp("throughput_s_ready", i, 32'(srdy[i]), 32'd1);
      if (n[i] > 0) begin
        cmp("m_data", i, 32'(act_data(i)), 32'(exp_q[i][0].data));
        cmp("m_keep", i, 32'(act_keep(i)), 32'(exp_q[i][0].keep));
        cmp("m_last", i, 32'(ml[i]), 32'(exp_q[i][0].last));
      end
    end
  endtask

  task automatic tick();
    for (int i = 0; i < 3; i++) model_step(i);
    mr_prev = mr;
    @(posedge clk);
    @(negedge clk);
    check_all();
  endtask

  initial begin
    logic [7:0]  pat;
    logic [15:0] two_words;
    rst_n = 1'b0;
    sv = '0; sl = '0; mr = '0;
    for (int i = 0; i < 3; i++) sd[i] = '0;
    model_reset();
    repeat (3) @(negedge clk);
    check_all();
    cmp("reset_m_data", 0, 32'(md0), 32'd0);
    cmp("reset_m_keep", 2, 32'(mk2), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check_all();

    // Bit pattern 1,0,1,1,0,0,1,0 on both 1-bit instances; 0xA then 0xB+last on the 4-bit one.
    pat = 8'b0100_1101;
    mr  = 3'b111;
    for (int k = 0; k < 8; k++) begin
      sv = 3'b011; sl = 3'b000;
      sd[0] = {3'b000, pat[k]};
      sd[1] = {3'b000, pat[k]};
      if (k < 2) begin
        sv[2] = 1'b1;
        sd[2] = (k == 0) ? 4'hA : 4'hB;
        sl[2] = (k == 1);
      end
      tick();
      if (k == 1) begin
        cmp("lit_w4_data", 2, 32'(md2), 32'h00BA);
        cmp("lit_w4_keep", 2, 32'(mk2), 32'h3);
        cmp("lit_w4_last", 2, 32'(ml[2]), 32'd1);
        cmp("lit_w4_valid", 2, 32'(mv[2]), 32'd1);
      end
      if (k == 6) cmp("lit_valid_early", 0, 32'(mv[0]), 32'd0);
    end
    cmp("lit_lsb_valid", 0, 32'(mv[0]), 32'd1);
    cmp("lit_lsb_data", 0, 32'(md0), 32'h4D);
    cmp("lit_lsb_keep", 0, 32'(mk0), 32'hFF);
    cmp("lit_msb_data", 1, 32'(md1), 32'hB2);
    sv = '0; sl = '0;
    tick();

    // Backpressure: 16 beats into inst0 with m_ready low.
    two_words = 16'h3CA5;
    mr = 3'b110;
    for (int k = 0; k < 16; k++) begin
      sv = 3'b001;
      sd[0] = {3'b000, two_words[k]};
      tick();
    end
    cmp("lit_bp_s_ready", 0, 32'(srdy[0]), 32'd0);
    cmp("lit_bp_first", 0, 32'(md0), 32'hA5);
    sv = '0;
    tick();
    cmp("lit_bp_hold", 0, 32'(md0), 32'hA5);
    mr = 3'b111;
    tick();
    cmp("lit_bp_second", 0, 32'(md0), 32'h3C);
    cmp("lit_bp_second_valid", 0, 32'(mv[0]), 32'd1);
    cmp("lit_bp_s_ready_back", 0, 32'(srdy[0]), 32'd1);
    tick();
    cmp("lit_bp_drained", 0, 32'(mv[0]), 32'd0);

    // Reset mid-word after 5 beats.
    for (int k = 0; k < 5; k++) begin
      sv = 3'b111; sl = '0;
      for (int i = 0; i < 3; i++) sd[i] = 4'hF;
      sl[2] = 1'b0;
      tick();
    end
    sv = '0;
    rst_n = 1'b0;
    model_reset();
    @(posedge clk);
    @(negedge clk);
    check_all();
    cmp("lit_rst_valid", 0, 32'(mv[0]), 32'd0);
    cmp("lit_rst_data", 0, 32'(md0), 32'd0);
    rst_n = 1'b1;
    tick();
    cmp("lit_rst_s_ready", 0, 32'(srdy[0]), 32'd1);
    for (int k = 0; k < 8; k++) begin
      sv = 3'b011;
      sd[0] = 4'h1; sd[1] = 4'h1;
      tick();
    end
    cmp("lit_rst_keep", 0, 32'(mk0), 32'hFF);
    cmp("lit_rst_data_full", 0, 32'(md0), 32'hFF);
    sv = '0;
    tick();

    // Randomised traffic with alternating free-running and random backpressure phases.
    acc0 = 0;
    for (int cyc = 0; cyc < 40000 && acc0 < 10000; cyc++) begin
      for (int i = 0; i < 3; i++) begin
        sv[i] = ($urandom_range(0, 3) != 0);
        sd[i] = 4'($urandom);
        sl[i] = ($urandom_range(0, 15) == 0);
        mr[i] = ((cyc / 500) % 2 == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      end
      tick();
    end
    cmp("beats_accepted", 0, 32'(acc0 >= 10000), 32'd1);

    sv = '0; sl = '0; mr = 3'b111;
    repeat (4) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
